// File: rtl/riscv_ahb_ram_ctrl_if.sv
// AHB3-Lite bus bundle between a master and the RAM controller slave.
// master modport: drives address/control/write data, receives HRDATA,
//                 HREADYOUT and HRESP.
// slave modport:  the reverse direction.
interface riscv_ahb_ram_ctrl_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/riscv_ahb_ram_ctrl.sv
// AHB3-Lite slave front-end for a single-port (1RW) RAM with registered
// read data. Turns AHB address/data phases into RAM cycles; a read that
// arrives while a write data phase owns the RAM port costs one wait state.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   ahb            AHB slave modport (HSEL..HREADY in, HRDATA/HREADYOUT/HRESP out)
//   ram_addr_o     RAM word address
//   ram_we_o       RAM write enable
//   ram_be_o       RAM byte enables
//   ram_din_o      RAM write data (HWDATA)
//   ram_dout_i     RAM read data, one cycle after address
module riscv_ahb_ram_ctrl #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int ABITS      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  riscv_ahb_ram_ctrl_if.slave     ahb,
  output logic [ABITS-1:0]        ram_addr_o,
  output logic                    ram_we_o,
  output logic [HDATA_SIZE/8-1:0] ram_be_o,
  output logic [HDATA_SIZE-1:0]   ram_din_o,
  input  logic [HDATA_SIZE-1:0]   ram_dout_i
);

  localparam int unsigned BE_W = HDATA_SIZE / 8;
  localparam int unsigned LSB  = $clog2(BE_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW
  } state_e;

  state_e            state_q, state_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              accept;
  logic              ready;
  logic [ABITS-1:0]  haddr_word;
  logic [BE_W-1:0]   be_calc;
  logic              unused_sig;

  assign haddr_word = ahb.HADDR[ABITS+LSB-1:LSB];
  assign accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign unused_sig = ^{ahb.HBURST, ahb.HPROT, ahb.HADDR};

  // A lane is enabled when it lies in the same naturally aligned
  // 2^HSIZE-byte block as the transfer address.
  always_comb begin : be_gen
    int unsigned sz;
    int unsigned off;
    be_calc = '0;
    sz      = 32'(ahb.HSIZE);
    off     = 32'(ahb.HADDR[LSB-1:0]);
    if (sz >= LSB) begin
      be_calc = '1;
    end else begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if ((i >> sz) == (off >> sz)) be_calc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    ready   = (state_q != ST_RDW);
    if (state_q == ST_RDW) begin
      state_d = ST_RD;
    end else if (accept) begin
      // addr_q serves both the write address and the deferred read address:
      // the write commits on the same edge that loads the read address.
      addr_d = haddr_word;
      if (ahb.HWRITE) begin
        state_d = ST_WR;
        be_d    = be_calc;
      end else if (state_q == ST_WR) begin
        state_d = ST_RDW;
      end else begin
        state_d = ST_RD;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  // Write enable is gated by reset so an in-flight write never reaches the RAM.
  assign ram_we_o   = rst_ni & (state_q == ST_WR);
  assign ram_be_o   = ram_we_o ? be_q : '0;
  assign ram_addr_o = ((state_q == ST_WR) || (state_q == ST_RDW)) ? addr_q : haddr_word;
  assign ram_din_o  = ahb.HWDATA;

  assign ahb.HRDATA    = ram_dout_i;
  assign ahb.HREADYOUT = ready;
  assign ahb.HRESP     = 1'b0;

endmodule

// File: tb/tb_riscv_ahb_ram_ctrl.sv
module tb_riscv_ahb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [3:0]  ebe;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] rd_exp_q[$];
  logic [3:0]  be_exp_q[$];

  always #5 clk = ~clk;

  riscv_ahb_ram_ctrl_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

  assign bus.HREADY = bus.HREADYOUT;

  riscv_ahb_ram_ctrl #(.HADDR_SIZE(32), .HDATA_SIZE(32), .ABITS(10)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ahb        (bus),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_be_o   (ram_be),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  // 1RW RAM model with registered read data
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    ram_dout <= mem[ram_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic beat_t mk(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input logic [3:0] ebe);
    beat_t b;
    b.trans = trans; b.wr = wr; b.size = size; b.addr = addr;
    b.wdata = wdata; b.exp = exp; b.ebe = ebe;
    return b;
  endfunction

  // Monitor: tracks data phases from bus activity alone, compares at negedge
  logic rd_pend = 1'b0;
  logic wr_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end else begin
      if (wr_pend) begin
        chk("wr_we", {31'b0, ram_we}, 32'd1);
        if (be_exp_q.size() == 0) chk("be_queue_empty", 32'd0, 32'd1);
        else chk("wr_be", {28'b0, ram_be}, {28'b0, be_exp_q.pop_front()});
      end else begin
        chk("no_write", {31'b0, ram_we}, 32'd0);
      end
      if (rd_pend && bus.HREADYOUT) begin
        if (rd_exp_q.size() == 0) chk("rd_queue_empty", 32'd0, 32'd1);
        else chk("hrdata", bus.HRDATA, rd_exp_q.pop_front());
      end
      if (bus.HREADYOUT) begin
        wr_pend = bus.HSEL & bus.HREADY & bus.HTRANS[1] & bus.HWRITE;
        rd_pend = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
      end
    end
  end

  task automatic run_seq(input string name, input int exp_waits);
    int          waits = 0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_wd = '0;
    logic        rdy;
    int          n;
    beats.push_back(mk(2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 4'h0));
    foreach (beats[i]) begin
      bus.HSEL   = 1'b1;
      bus.HTRANS = beats[i].trans;
      bus.HWRITE = beats[i].wr;
      bus.HSIZE  = beats[i].size;
      bus.HADDR  = beats[i].addr;
      bus.HWDATA = prev_wr ? prev_wd : 32'hBADBAD00;
      if (beats[i].trans[1]) begin
        if (beats[i].wr) be_exp_q.push_back(beats[i].ebe);
        else rd_exp_q.push_back(beats[i].exp);
      end
      n = 0;
      do begin
        @(negedge clk);
        rdy = bus.HREADYOUT;
        if (!rdy) waits++;
        @(posedge clk);
        #1;
        n++;
      end while (!rdy && n < 8);
      if (!rdy) chk({name, "_timeout"}, 32'd0, 32'd1);
      prev_wr = beats[i].trans[1] & beats[i].wr;
      prev_wd = beats[i].wdata;
    end
    chk({name, "_waits"}, waits, exp_waits);
    beats.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HWDATA = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd2;
    bus.HBURST = 3'd0;
    bus.HPROT  = 4'd0;
    bus.HTRANS = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
    chk("rst_we", {31'b0, ram_we}, 32'd0);
    chk("rst_be", {28'b0, ram_be}, 32'd0);
    rst_n = 1'b1;

    // write, idle, read: no wait states
    beats.push_back(mk(2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 4'hF));
    beats.push_back(mk(2'd0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 4'h0));
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 4'h0));
    run_seq("wr_idle_rd", 0);

    // read-after-write to the same word: one wait, new data
    beats.push_back(mk(2'd2, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0, 4'hF));
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 4'h0));
    run_seq("raw_hazard", 1);

    // byte and halfword lanes
    beats.push_back(mk(2'd2, 1'b1, 3'd2, 32'h30, 32'h11223344, 32'h0, 4'hF));
    beats.push_back(mk(2'd2, 1'b1, 3'd0, 32'h31, 32'h0000AA00, 32'h0, 4'b0010));
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h30, 32'h0, 32'h1122AA44, 4'h0));
    beats.push_back(mk(2'd2, 1'b1, 3'd1, 32'h32, 32'h55660000, 32'h0, 4'b1100));
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h30, 32'h0, 32'h5566AA44, 4'h0));
    run_seq("byte_half", 2);

    // write burst with a BUSY beat, then read burst
    beats.push_back(mk(2'd2, 1'b1, 3'd2, 32'h40, 32'hA0A0A0A0, 32'h0, 4'hF));
    beats.push_back(mk(2'd3, 1'b1, 3'd2, 32'h44, 32'hB1B1B1B1, 32'h0, 4'hF));
    beats.push_back(mk(2'd1, 1'b1, 3'd2, 32'h48, 32'h0, 32'h0, 4'h0));
    beats.push_back(mk(2'd3, 1'b1, 3'd2, 32'h48, 32'hC2C2C2C2, 32'h0, 4'hF));
    beats.push_back(mk(2'd3, 1'b1, 3'd2, 32'h4C, 32'hD3D3D3D3, 32'h0, 4'hF));
    beats.push_back(mk(2'd3, 1'b0, 3'd2, 32'h40, 32'h0, 32'hA0A0A0A0, 4'h0));
    beats.push_back(mk(2'd3, 1'b0, 3'd2, 32'h44, 32'h0, 32'hB1B1B1B1, 4'h0));
    beats.push_back(mk(2'd3, 1'b0, 3'd2, 32'h48, 32'h0, 32'hC2C2C2C2, 4'h0));
    beats.push_back(mk(2'd3, 1'b0, 3'd2, 32'h4C, 32'h0, 32'hD3D3D3D3, 4'h0));
    run_seq("burst", 1);

    // reset asserted while the delayed read is waiting
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'd2;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = 3'd2;
    bus.HADDR  = 32'h50;
    be_exp_q.push_back(4'hF);
    @(posedge clk);
    #1;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h10;
    bus.HWDATA = 32'h0BADF00D;
    @(posedge clk);
    #1;
    chk("rdw_wait", {31'b0, bus.HREADYOUT}, 32'd0);
    rst_n      = 1'b0;
    bus.HTRANS = 2'd0;
    @(negedge clk);
    chk("rdw_rst_we", {31'b0, ram_we}, 32'd0);
    @(posedge clk);
    #1;
    chk("rdw_rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    chk("rdw_rst_we_after", {31'b0, ram_we}, 32'd0);
    chk("rdw_rst_be", {28'b0, ram_be}, 32'd0);
    rst_n = 1'b1;
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 4'h0));
    beats.push_back(mk(2'd2, 1'b0, 3'd2, 32'h50, 32'h0, 32'h0BADF00D, 4'h0));
    run_seq("post_rst_rd", 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_exp_drained", rd_exp_q.size(), 32'd0);
    chk("be_exp_drained", be_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
